// File: rtl/divisor_frecuencia_prog_if.sv
// Bus bundle for the programmable frequency divider: per-channel enables,
// the shared divisor write port and the registered per-channel outputs.
interface divisor_frecuencia_prog_if #(
    parameter int ANCHO       = 25,
    parameter int NUM_CANALES = 4,
    parameter int SEL_W       = (NUM_CANALES > 1) ? $clog2(NUM_CANALES) : 1
);
    // wr_en is a one-cycle strobe with no ready: every write is taken on the
    // rising edge where wr_en=1, or silently dropped when the data is zero
    // or the channel address is out of range.
    logic [NUM_CANALES-1:0] en;
    logic                   wr_en;
    logic [SEL_W-1:0]       wr_canal;
    logic [ANCHO-1:0]       wr_dato;
    logic [NUM_CANALES-1:0] clk_Salida;
    logic [NUM_CANALES-1:0] tick;
    logic [NUM_CANALES-1:0] pendiente;

    modport master (
        output en, wr_en, wr_canal, wr_dato,
        input  clk_Salida, tick, pendiente
    );

    modport slave (
        input  en, wr_en, wr_canal, wr_dato,
        output clk_Salida, tick, pendiente
    );
endinterface

// File: rtl/divisor_frecuencia_prog.sv
// Multi-channel programmable frequency divider: each channel produces a
// square wave of period 2*D and a tick at every half-period boundary.
module divisor_frecuencia_prog #(
    parameter int ANCHO       = 25,
    parameter int NUM_CANALES = 4,
    parameter int DIV_INICIAL = 25000000,
    parameter int SEL_W       = (NUM_CANALES > 1) ? $clog2(NUM_CANALES) : 1
) (
    input  logic                       clk_Entrada,
    input  logic                       rst,
    divisor_frecuencia_prog_if.slave   bus
);
    localparam logic [ANCHO-1:0] DIV_RST = ANCHO'(DIV_INICIAL);
    localparam logic [ANCHO-1:0] UNO     = ANCHO'(1);

    logic                   dato_valido;
    logic [NUM_CANALES-1:0] sal_v;
    logic [NUM_CANALES-1:0] tick_v;
    logic [NUM_CANALES-1:0] pend_v;

    // A zero divisor would never reach a boundary, so it is dropped here.
    assign dato_valido = bus.wr_en && (bus.wr_dato != '0);

    for (genvar c = 0; c < NUM_CANALES; c++) begin : g_canal
        logic [ANCHO-1:0] activo;
        logic [ANCHO-1:0] sombra;
        logic [ANCHO-1:0] contador;
        logic             sal_q;
        logic             tick_q;
        logic             pend_q;
        logic             escribe;
        logic             frontera;
        logic             aplica;

        assign escribe  = dato_valido && (bus.wr_canal == SEL_W'(c));
        assign frontera = bus.en[c] && (contador == activo - UNO);
        // Swapping only when the count restarts at 0 keeps every half-period
        // whole, whatever the new value is.
        assign aplica   = pend_q && (frontera || !bus.en[c]);

        always_ff @(posedge clk_Entrada or posedge rst) begin
            if (rst) begin
                activo   <= DIV_RST;
                sombra   <= DIV_RST;
                contador <= '0;
                sal_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                if (bus.en[c]) begin
                    if (frontera) begin
                        contador <= '0;
                        sal_q    <= ~sal_q;
                        tick_q   <= 1'b1;
                    end else begin
                        contador <= contador + UNO;
                        tick_q   <= 1'b0;
                    end
                end else begin
                    contador <= '0;
                    tick_q   <= 1'b0;
                end

                if (aplica) begin
                    activo <= sombra;
                end

                // A write on the swap edge wins: it stays pending for the next boundary.
                if (escribe) begin
                    sombra <= bus.wr_dato;
                    pend_q <= 1'b1;
                end else if (aplica) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign sal_v[c]  = sal_q;
        assign tick_v[c] = tick_q;
        assign pend_v[c] = pend_q;
    end

    assign bus.clk_Salida = sal_v;
    assign bus.tick       = tick_v;
    assign bus.pendiente  = pend_v;
endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Directed bench for divisor_frecuencia_prog: five channels, D=5 at reset,
// hand-computed tick/clk_Salida/pendiente sequences per test step.
module tb_divisor_frecuencia_prog;
  localparam int ANCHO = 8;
  localparam int NC    = 5;
  localparam int DIV0  = 5;
  localparam int SW    = 3;

  logic clk_Entrada = 1'b0;
  logic rst         = 1'b1;
  int   checks      = 0;
  int   failures    = 0;
  int   k           = 0;
  logic [31:0] exp_q[$];
  logic exp_t;

  divisor_frecuencia_prog_if #(.ANCHO(ANCHO), .NUM_CANALES(NC), .SEL_W(SW)) bus ();

  divisor_frecuencia_prog #(
    .ANCHO(ANCHO), .NUM_CANALES(NC), .DIV_INICIAL(DIV0), .SEL_W(SW)
  ) dut (
    .clk_Entrada(clk_Entrada),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk_Entrada = ~clk_Entrada;

  // one rising edge, then sample and drive at the following falling edge
  task automatic paso();
    @(posedge clk_Entrada);
    @(negedge clk_Entrada);
    k++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.en     = '0;
    bus.wr_en  = 1'b0;
    @(negedge clk_Entrada);
    rst        = 1'b0;
    bus.en     = '1;
    k          = 0;
  endtask

  task automatic wr(input logic [SW-1:0] c, input logic [ANCHO-1:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_canal = c;
    bus.wr_dato  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  initial begin
    bus.en       = '0;
    bus.wr_en    = 1'b0;
    bus.wr_canal = '0;
    bus.wr_dato  = '0;

    // reset state
    @(negedge clk_Entrada);
    chk("rst clk_Salida", 32'(bus.clk_Salida), 32'(0));
    chk("rst tick", 32'(bus.tick), 32'(0));
    chk("rst pendiente", 32'(bus.pendiente), 32'(0));

    // default divisor on every channel: tick every 5, period 10
    do_reset();
    exp_q = {32'd5, 32'd10, 32'd15, 32'd20};
    repeat (20) begin
      paso();
      exp_t = (exp_q.size() > 0) && (exp_q[0] == 32'(k));
      if (exp_t) void'(exp_q.pop_front());
      chk("t1 tick", 32'(bus.tick), 32'({NC{exp_t}}));
      chk("t1 clk_Salida", 32'(bus.clk_Salida), 32'({NC{((k / 5) % 2) == 1}}));
    end

    // runtime reload of ch1 to 3 in the middle of the first half-period
    do_reset();
    repeat (14) begin
      paso();
      chk("t2 pend1", 32'(bus.pendiente[1]), 32'(k >= 2 && k <= 4));
      chk("t2 tick1", 32'(bus.tick[1]), 32'(k inside {5, 8, 11, 14}));
      chk("t2 sal1", 32'(bus.clk_Salida[1]), 32'((k >= 5 && k < 8) || (k >= 11 && k < 14)));
      chk("t2 tick0", 32'(bus.tick[0]), 32'(k inside {5, 10}));
      if (k == 1) wr(3'd1, 8'd3);
      if (k == 2) bus.wr_en = 1'b0;
    end

    // ch2: 7 then 2 before the boundary, 4 on the boundary edge
    do_reset();
    wr(3'd2, 8'd7);
    repeat (15) begin
      paso();
      if (k == 1) bus.wr_en = 1'b0;
      if (k == 2) wr(3'd2, 8'd2);
      if (k == 3) bus.wr_en = 1'b0;
      if (k == 4) wr(3'd2, 8'd4);
      if (k == 5) bus.wr_en = 1'b0;
      chk("t3 pend2", 32'(bus.pendiente[2]), 32'(k <= 6));
      chk("t3 tick2", 32'(bus.tick[2]), 32'(k inside {5, 7, 11, 15}));
      chk("t3 sal2", 32'(bus.clk_Salida[2]), 32'((k >= 5 && k < 7) || (k >= 11 && k < 15)));
    end

    // illegal writes: zero data, then out-of-range channels 5 and 7
    do_reset();
    wr(3'd0, 8'd0);
    repeat (10) begin
      paso();
      chk("t4 pendiente", 32'(bus.pendiente), 32'(0));
      chk("t4 tick", 32'(bus.tick), 32'({NC{(k % 5) == 0}}));
      chk("t4 clk_Salida", 32'(bus.clk_Salida), 32'({NC{((k / 5) % 2) == 1}}));
      if (k == 1) wr(3'd5, 8'd9);
      if (k == 2) wr(3'd7, 8'd9);
      if (k == 3) bus.wr_en = 1'b0;
    end

    // ch3 disabled with clk_Salida high, reloaded to 2 while off, re-enabled
    do_reset();
    repeat (18) begin
      paso();
      chk("t5 tick3", 32'(bus.tick[3]), 32'(k inside {5, 14, 16, 18}));
      chk("t5 sal3", 32'(bus.clk_Salida[3]),
          32'((k >= 5 && k < 14) || (k >= 16 && k < 18)));
      chk("t5 pend3", 32'(bus.pendiente[3]), 32'(k == 7));
      if (k == 5)  bus.en[3] = 1'b0;
      if (k == 6)  wr(3'd3, 8'd2);
      if (k == 7)  bus.wr_en = 1'b0;
      if (k == 12) bus.en[3] = 1'b1;
    end

    // ch4 reloaded to 1: continuous tick, toggle every cycle
    do_reset();
    wr(3'd4, 8'd1);
    repeat (8) begin
      paso();
      if (k == 1) bus.wr_en = 1'b0;
      chk("t6 pend4", 32'(bus.pendiente[4]), 32'(k <= 4));
      chk("t6 tick4", 32'(bus.tick[4]), 32'(k >= 5));
      chk("t6 sal4", 32'(bus.clk_Salida[4]), 32'(k >= 5 && (k % 2) == 1));
    end

    // async reset between edges while ch0 has a pending divisor
    do_reset();
    repeat (5) begin
      paso();
      if (k == 4) wr(3'd0, 8'd2);
    end
    bus.wr_en = 1'b0;
    chk("t7 pre pendiente", 32'(bus.pendiente), 32'(1));
    chk("t7 pre tick", 32'(bus.tick), 32'({NC{1'b1}}));
    rst = 1'b1;
    #1;
    chk("t7 async clk_Salida", 32'(bus.clk_Salida), 32'(0));
    chk("t7 async tick", 32'(bus.tick), 32'(0));
    chk("t7 async pendiente", 32'(bus.pendiente), 32'(0));
    #1;
    rst = 1'b0;
    k   = 0;
    repeat (10) begin
      paso();
      chk("t7 pendiente", 32'(bus.pendiente), 32'(0));
      chk("t7 tick0", 32'(bus.tick[0]), 32'((k % 5) == 0));
      chk("t7 sal0", 32'(bus.clk_Salida[0]), 32'(((k / 5) % 2) == 1));
    end

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
